sub_serial: RTL and testbench



---
 rtl/sub_serial.sv | 141 ++++++++++++++
 tb/tb_sub_serial.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/sub_serial.sv
// sub_serial: bit-serial subtractor computing r1 - r2 - bin one bit per clock.
// A single full-subtractor cell walks the operands LSB first while the
// difference is shifted into a register from the top. result and borrow are
// loaded once, on the edge that finishes the last bit, and then hold until the
// next operation completes. busy and done are decoded straight from the state
// flops, so no input reaches an output without passing through a register.

// One-bit full subtractor: d = a - b - bi, bo set when a < b + bi.
module sub_serial_cell (
  input  logic a,
  input  logic b,
  input  logic bi,
  output logic d,
  output logic bo
);

  assign d  = a ^ b ^ bi;
  assign bo = (~a & b) | (~(a ^ b) & bi);

endmodule

module sub_serial #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] r1,
  input  logic [WIDTH-1:0] r2,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             borrow
);

  // Counter just wide enough to index bits 0..WIDTH-1.
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  // Operand shift registers: bit 0 always holds the bit being processed.
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  // Difference register: new bits enter at the MSB and move right, so after
  // WIDTH shifts bit 0 holds the first difference bit computed.
  logic [WIDTH-1:0] d_sr;
  logic             br;
  logic [CW-1:0]    cnt;

  logic             accept;
  logic             last;
  logic             d_bit;
  logic             br_nxt;

  // A new operation may be accepted whenever no operation is in flight;
  // start during RUN is deliberately ignored.
  assign accept = start && ((state == IDLE) || (state == DONE));
  assign last   = (cnt == LAST_BIT);

  sub_serial_cell u_cell (
    .a  (a_sr[0]),
    .b  (b_sr[0]),
    .bi (br),
    .d  (d_bit),
    .bo (br_nxt)
  );

  // Next-state logic for the IDLE -> RUN -> DONE sequence.
  always_comb begin
    // NOTE: default first so every path assigns state_nxt and no latch is inferred.
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = RUN;
      RUN:  if (last)   state_nxt = DONE;
      DONE: state_nxt = accept ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register; reset aborts any operation in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of block ordering.
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Serial datapath: capture operands on accept, then shift one bit per RUN cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: these are plain registers, not a memory array, so each one gets
    // an explicit reset value and an aborted operation leaves nothing behind.
    if (!rst_n) begin
      a_sr <= '0;
      b_sr <= '0;
      d_sr <= '0;
      br   <= 1'b0;
      cnt  <= '0;
    end else if (accept) begin
      a_sr <= r1;
      b_sr <= r2;
      d_sr <= '0;
      br   <= bin;
      cnt  <= '0;
    end else if (state == RUN) begin
      a_sr <= a_sr >> 1;
      b_sr <= b_sr >> 1;
      d_sr <= {d_bit, d_sr[WIDTH-1:1]};
      br   <= br_nxt;
      cnt  <= cnt + CW'(1);
    end
  end

  // Result registers: loaded only on the edge that processes the last bit,
  // so they stay stable through RUN and hold between operations.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result <= '0;
      borrow <= 1'b0;
    end else if ((state == RUN) && last) begin
      result <= {d_bit, d_sr[WIDTH-1:1]};
      borrow <= br_nxt;
    end
  end

  // Handshake outputs are pure decodes of the state flops.
  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule

// File: tb/tb_sub_serial.sv
// Self-checking bench for sub_serial: an expectation queue is filled when an
// operation is accepted and drained whenever done is seen.
module tb_sub_serial;

  localparam int W = 4;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] r1;
  logic [W-1:0] r2;
  logic         bin;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         borrow;

  int n_tests;
  int n_fail;
  int done_seen;

  logic [W:0] sb[$];

  sub_serial #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .r1     (r1),
    .r2     (r2),
    .bin    (bin),
    .busy   (busy),
    .done   (done),
    .result (result),
    .borrow (borrow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic bi);
    logic [W:0] t;
    t = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bi};
    return t;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && busy && done) check("busy_and_done", 1, 0);
    if (rst_n && done) begin
      logic [W:0] e;
      done_seen++;
      if (sb.size() == 0) begin
        check("spurious_done", 1, 0);
      end else begin
        e = sb.pop_front();
        check("result", 32'(result), 32'(e[W-1:0]));
        check("borrow", 32'(borrow), 32'(e[W]));
      end
    end
  end

  // Run one operation. Entered #1 after a posedge with the DUT not in RUN.
  // inject pulses start with r1=r2=15 two cycles into RUN.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi,
                        input bit inject, input bit chk_timing);
    int edges;
    int busy_cnt;
    int d0;
    r1    = a;
    r2    = b;
    bin   = bi;
    start = 1'b1;
    sb.push_back(model(a, b, bi));
    d0 = done_seen;
    @(posedge clk);
    #1;
    start = 1'b0;
    // Scramble operands: only the accepted values may matter.
    r1  = W'($urandom);
    r2  = W'($urandom);
    bin = 1'($urandom);
    edges    = 0;
    busy_cnt = 0;
    while (!done && edges < 20) begin
      if (busy) busy_cnt++;
      if (inject && edges == 1) begin
        start = 1'b1;
        r1    = '1;
        r2    = '1;
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      edges++;
    end
    if (!done) check("done_timeout", 0, 1);
    if (chk_timing) begin
      check("latency", 32'(edges), 32'(W));
      check("busy_cycles", 32'(busy_cnt), 32'(W));
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      check("busy_after_done", 32'(busy), 0);
      check("done_pulses", 32'(done_seen - d0), 1);
    end
  endtask

  initial begin
    int edges;
    n_tests   = 0;
    n_fail    = 0;
    done_seen = 0;
    rst_n = 1'b0;
    start = 1'b0;
    r1    = '0;
    r2    = '0;
    bin   = 1'b0;

    #12;
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_result", 32'(result), 0);
    check("rst_borrow", 32'(borrow), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed cases.
    run_op(4'd10, 4'd2, 1'b0, 1'b0, 1'b1);
    run_op(4'd2, 4'd10, 1'b0, 1'b0, 1'b1);
    run_op(4'd10, 4'd2, 1'b1, 1'b0, 1'b1);
    run_op(4'd0, 4'd0, 1'b1, 1'b0, 1'b1);

    // start mid-RUN must be ignored.
    run_op(4'd10, 4'd2, 1'b0, 1'b1, 1'b1);
    check("queue_empty_after_inject", 32'(sb.size()), 0);

    // Asynchronous reset two cycles into RUN.
    r1    = 4'd10;
    r2    = 4'd3;
    bin   = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("midrun_rst_busy", 32'(busy), 0);
    check("midrun_rst_done", 32'(done), 0);
    check("midrun_rst_result", 32'(result), 0);
    check("midrun_rst_borrow", 32'(borrow), 0);
    sb.delete();
    begin
      int d0;
      d0 = done_seen;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (8) @(posedge clk);
      #1;
      check("no_done_after_abort", 32'(done_seen - d0), 0);
    end
    run_op(4'd5, 4'd3, 1'b0, 1'b0, 1'b1);

    // Back-to-back with start held through the done cycle.
    r1    = 4'd9;
    r2    = 4'd4;
    bin   = 1'b0;
    start = 1'b1;
    sb.push_back(model(4'd9, 4'd4, 1'b0));
    @(posedge clk);
    #1;
    edges = 0;
    while (!done && edges < 20) begin
      @(posedge clk);
      #1;
      edges++;
    end
    check("b2b_first_latency", 32'(edges), 32'(W));
    r1 = 4'd3;
    r2 = 4'd7;
    sb.push_back(model(4'd3, 4'd7, 1'b0));
    @(posedge clk);
    #1;
    start = 1'b0;
    edges = 1;
    while (!done && edges < 20) begin
      @(posedge clk);
      #1;
      edges++;
    end
    check("b2b_second_spacing", 32'(edges), 32'(W + 1));
    @(posedge clk);
    #1;

    // Exhaustive sweep over all operand and borrow-in combinations.
    for (int i = 0; i < 512; i++) begin
      run_op(W'(i >> 5), W'(i >> 1), 1'(i), 1'b0, 1'b0);
    end
    @(posedge clk);
    #1;
    check("queue_empty_at_end", 32'(sb.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Watchdog so a stuck DUT cannot hang the run.
  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
